// File: rtl/mem_wb_elastic.sv
// MEM/WB elastic stage: carries a LANES-wide writeback bundle under valid/ready,
// with an optional two-entry skid buffer, synchronous flush and bubble zeroing.
module mem_wb_elastic #(
    parameter int WIDTH = 70,
    parameter int LANES = 2,
    parameter int SKID  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES-1:0]       in_we,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [LANES-1:0]       out_we,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy
);
    localparam int DW = LANES * WIDTH;

    // Main entry M drives the outputs; skid entry S only fills when M is stalled.
    logic             r_m_valid;
    logic [LANES-1:0] r_m_we;
    logic [DW-1:0]    r_m_data;
    logic             r_s_valid;
    logic [LANES-1:0] r_s_we;
    logic [DW-1:0]    r_s_data;
    logic             r_in_ready;
    logic [1:0]       r_occupancy;

    logic             w_m_valid_next;
    logic [LANES-1:0] w_m_we_next;
    logic [DW-1:0]    w_m_data_next;
    logic             w_s_valid_next;
    logic [LANES-1:0] w_s_we_next;
    logic [DW-1:0]    w_s_data_next;
    logic             w_in_ready_next;
    logic [1:0]       w_occupancy_next;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // With a skid entry the ready is a flop; without it, it looks through to out_ready.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (~r_m_valid | out_ready);
    assign w_in_fire  = in_valid & w_in_ready & ~flush;
    assign w_out_fire = r_m_valid & out_ready;

    always_comb begin
        w_m_valid_next = r_m_valid;
        w_m_we_next    = r_m_we;
        w_m_data_next  = r_m_data;
        w_s_valid_next = r_s_valid;
        w_s_we_next    = r_s_we;
        w_s_data_next  = r_s_data;

        if (flush) begin
            w_m_valid_next = 1'b0;
            w_m_we_next    = '0;
            w_m_data_next  = '0;
            w_s_valid_next = 1'b0;
            w_s_we_next    = '0;
            w_s_data_next  = '0;
        end else if (SKID != 0) begin
            if (!r_m_valid || w_out_fire) begin
                // M is free this edge: S (older) advances first to keep order.
                if (r_s_valid) begin
                    w_m_valid_next = 1'b1;
                    w_m_we_next    = r_s_we;
                    w_m_data_next  = r_s_data;
                    if (w_in_fire) begin
                        w_s_valid_next = 1'b1;
                        w_s_we_next    = in_we;
                        w_s_data_next  = in_data;
                    end else begin
                        w_s_valid_next = 1'b0;
                        w_s_we_next    = '0;
                        w_s_data_next  = '0;
                    end
                end else if (w_in_fire) begin
                    w_m_valid_next = 1'b1;
                    w_m_we_next    = in_we;
                    w_m_data_next  = in_data;
                end else begin
                    w_m_valid_next = 1'b0;
                    w_m_we_next    = '0;
                    w_m_data_next  = '0;
                end
            end else if (w_in_fire) begin
                w_s_valid_next = 1'b1;
                w_s_we_next    = in_we;
                w_s_data_next  = in_data;
            end
        end else begin
            if (w_in_fire) begin
                w_m_valid_next = 1'b1;
                w_m_we_next    = in_we;
                w_m_data_next  = in_data;
            end else if (w_out_fire) begin
                w_m_valid_next = 1'b0;
                w_m_we_next    = '0;
                w_m_data_next  = '0;
            end
        end

        // S never holds anything in the single-register build.
        if (SKID == 0) begin
            w_s_valid_next = 1'b0;
            w_s_we_next    = '0;
            w_s_data_next  = '0;
        end

        w_in_ready_next  = ~w_s_valid_next;
        w_occupancy_next = {1'b0, w_m_valid_next} + {1'b0, w_s_valid_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_we      <= '0;
            r_m_data    <= '0;
            r_s_valid   <= 1'b0;
            r_s_we      <= '0;
            r_s_data    <= '0;
            r_in_ready  <= 1'b1;
            r_occupancy <= 2'd0;
        end else begin
            r_m_valid   <= w_m_valid_next;
            r_m_we      <= w_m_we_next;
            r_m_data    <= w_m_data_next;
            r_s_valid   <= w_s_valid_next;
            r_s_we      <= w_s_we_next;
            r_s_data    <= w_s_data_next;
            r_in_ready  <= w_in_ready_next;
            r_occupancy <= w_occupancy_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_m_valid;
    assign out_we    = r_m_we & {LANES{r_m_valid}};
    assign out_data  = r_m_data;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Directed bench for mem_wb_elastic: a SKID=1 two-lane instance and a
// SKID=0 single-lane 32-bit instance, driven from hand-computed vectors.
module tb_mem_wb_elastic;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: defaults (WIDTH=70, LANES=2, SKID=1)
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]   a_in_we, a_out_we, a_occ;
    logic [139:0] a_in_data, a_out_data;

    // Instance B: SKID=0, LANES=1, WIDTH=32
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]   b_in_we, b_out_we;
    logic [1:0]   b_occ;
    logic [31:0]  b_in_data, b_out_data;

    mem_wb_elastic #(.WIDTH(70), .LANES(2), .SKID(1)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_we(a_in_we), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_we(a_out_we), .out_data(a_out_data),
        .out_ready(a_out_ready), .occupancy(a_occ)
    );

    mem_wb_elastic #(.WIDTH(32), .LANES(1), .SKID(0)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_we(b_in_we), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_we(b_out_we), .out_data(b_out_data),
        .out_ready(b_out_ready), .occupancy(b_occ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [139:0] bundle(input logic [69:0] l0, input logic [69:0] l1);
        return {l1, l0};
    endfunction

    logic [143:0] pat_a5;
    int idx, ncons;

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_we = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_we = 0; b_in_data = '0; b_out_ready = 0;
        tick; tick;
        rst = 1'b0;
        tick;
        check("a_reset_valid", a_out_valid, 0);
        check("a_reset_occ", a_occ, 0);
        check("a_reset_ready", a_in_ready, 1);
        check("b_reset_occ", b_occ, 0);

        // Reset with both entries full
        pat_a5 = {18{8'hA5}};
        a_in_valid = 1; a_in_we = 2'b11; a_in_data = pat_a5[139:0]; a_out_ready = 0;
        tick; tick;
        check("a_full_occ", a_occ, 2);
        check("a_full_ready", a_in_ready, 0);
        a_in_valid = 0; rst = 1;
        tick;
        check("rst_valid", a_out_valid, 0);
        check("rst_we", a_out_we, 0);
        check("rst_data", a_out_data, 0);
        check("rst_occ", a_occ, 0);
        rst = 0;
        tick;
        check("rst_ready", a_in_ready, 1);

        // Streaming B0..B7 with out_ready=1
        a_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1; a_in_we = 2'b11; a_in_data = bundle(70'(i), 70'(32'h100 + i));
            tick;
            check($sformatf("stream_valid%0d", i), a_out_valid, 1);
            check($sformatf("stream_data%0d", i), a_out_data, bundle(70'(i), 70'(32'h100 + i)));
            check($sformatf("stream_occ%0d", i), a_occ, 1);
        end
        a_in_valid = 0;
        tick;
        check("stream_end_valid", a_out_valid, 0);
        check("stream_end_occ", a_occ, 0);

        // Backpressure: B0 in M, B1 into S, B2 held
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = bundle(70'h0, 70'h100);
        tick;
        check("bp_m_b0", a_out_data, bundle(70'h0, 70'h100));
        a_in_data = bundle(70'h1, 70'h101);
        tick;
        check("bp_occ2", a_occ, 2);
        check("bp_ready0", a_in_ready, 0);
        a_in_data = bundle(70'h2, 70'h102);
        tick;
        check("bp_hold_b0", a_out_data, bundle(70'h0, 70'h100));
        check("bp_hold_occ", a_occ, 2);
        a_out_ready = 1;
        tick;
        check("bp_out_b1", a_out_data, bundle(70'h1, 70'h101));
        check("bp_ready1", a_in_ready, 1);
        check("bp_occ1", a_occ, 1);
        tick;
        check("bp_out_b2", a_out_data, bundle(70'h2, 70'h102));
        check("bp_occ_b2", a_occ, 1);
        a_in_valid = 0;
        tick;
        check("bp_drain_valid", a_out_valid, 0);

        // Flush with M and S full plus a new offer
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = bundle(70'h3, 70'h103);
        tick;
        a_in_data = bundle(70'h4, 70'h104);
        tick;
        check("fl_pre_occ", a_occ, 2);
        a_in_data = bundle(70'h5, 70'h105); a_flush = 1;
        tick;
        a_flush = 0; a_in_valid = 0;
        check("fl_occ", a_occ, 0);
        check("fl_we", a_out_we, 0);
        check("fl_data", a_out_data, 0);
        check("fl_ready", a_in_ready, 1);
        tick;
        check("fl_no_b5", a_out_valid, 0);

        // Flush overrides an offer that would otherwise be accepted
        a_in_valid = 1; a_in_data = bundle(70'h6, 70'h106);
        tick;
        check("fl2_pre_occ", a_occ, 1);
        a_in_data = bundle(70'h7, 70'h107); a_flush = 1;
        tick;
        a_flush = 0; a_in_valid = 0;
        check("fl2_occ", a_occ, 0);
        check("fl2_valid", a_out_valid, 0);

        // Bubble after a lone bundle with partial write enable
        a_out_ready = 1;
        a_in_valid = 1; a_in_we = 2'b01; a_in_data = bundle(70'h55, 70'h66);
        tick;
        a_in_valid = 0;
        check("bub_we", a_out_we, 2'b01);
        check("bub_data", a_out_data, bundle(70'h55, 70'h66));
        tick;
        check("bub_valid", a_out_valid, 0);
        check("bub_we0", a_out_we, 0);
        check("bub_data0", a_out_data, 0);

        // SKID=0: combinational ready follows out_ready while M is full
        b_out_ready = 0; b_in_valid = 1; b_in_we = 1; b_in_data = 32'h10;
        #1;
        check("b_ready_empty", b_in_ready, 1);
        tick;
        check("b_m_0x10", b_out_data, 32'h10);
        check("b_ready_lo", b_in_ready, 0);
        b_out_ready = 1;
        #1;
        check("b_ready_hi", b_in_ready, 1);
        b_out_ready = 0;
        #1;
        check("b_ready_lo2", b_in_ready, 0);

        // Alternating out_ready over 0x10..0x17 (0x10 already in M)
        idx = 1; ncons = 0;
        for (int c = 0; c < 40 && ncons < 8; c++) begin
            b_out_ready = (c % 2 == 0);
            b_in_valid  = (idx < 8);
            b_in_data   = 32'h10 + idx;
            #1;
            if (b_out_valid && b_out_ready) begin
                check($sformatf("b_word%0d", ncons), b_out_data, 32'h10 + ncons);
                ncons++;
            end
            if (b_in_valid && b_in_ready) idx++;
            tick;
        end
        check("b_count", ncons, 8);
        b_in_valid = 0; b_out_ready = 0;
        tick;
        check("b_empty", b_out_valid, 0);
        check("b_occ0", b_occ, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_wb_elastic.md
# mem_wb_elastic

Parametrised successor of the single-lane MEM/WB stage register. Carries a bundle of `LANES` writeback payloads from the memory stage to write-back under a valid/ready handshake instead of global stall wires. It has an optional two-entry skid buffer for a registered `in_ready`, synchronous flush, and bubble zeroing. Occupancy is exported to the hazard unit.

## Interface
Parameters:
- `WIDTH`, default 70: payload bits per lane (pc + wdata + waddr + side fields, packed by the caller).
- `LANES`, default 2: writeback lanes per bundle; all lanes advance together.
- `SKID`, default 1:
  - 1 = two-entry skid buffer with registered `in_ready`.
  - 0 = single register with combinational `in_ready`.

Ports:
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `flush`  in  1  discard all held bundles (exception/eret).
- `in_valid`  in  1  MEM stage offers a bundle.
- `in_we`  in  LANES  per-lane write enable.
- `in_data`  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  1  stage accepts this cycle.
- `out_valid`  out  1  bundle presented to WB.
- `out_we`  out  LANES  per-lane write enable, always 0 when `out_valid`=0.
- `out_data`  out  LANES*WIDTH  presented payload.
- `out_ready`  in  1  WB consumes this cycle.
- `occupancy`  out  2  held bundles, 0..2 (max 1 when SKID=0).

## Operation
- `in_fire` = `in_valid` & `in_ready` & ~`flush`; `out_fire` = `out_valid` & `out_ready`.
- Storage:
  - main entry M drives the outputs directly.
  - skid entry S exists only when SKID=1.
- SKID=1:
  - `in_ready` = ~S.valid, driven from a flop.
  - M empty, or `out_fire`: accepted data goes to M. If S is valid, S moves to M first, the new bundle goes to S, and order is preserved.
  - M full and no `out_fire`: accepted data goes to S.
  - S can only fill when M is full.
- SKID=0:
  - `in_ready` = ~M.valid | `out_ready`.
  - `in_fire` loads M.
  - `out_fire` without `in_fire` empties M.
- Bubble: when an entry empties, its valid bit, write enables and payload all go to zero. No stale write enable reaches WB.
- `flush`:
  - clears M and S (valid, we, data = 0) at the next edge.
  - overrides `in_fire` in the same cycle.
  - the `out_fire` in the flush cycle still counts as consumed by WB.
- `rst` has priority over `flush`. Reset values:
  - `out_valid`=0, `out_we`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
- `occupancy` = M.valid + S.valid, registered.
- Lanes are never reordered or split. A bundle is accepted and retired atomically.

## Timing
- Latency: `in_fire` at edge N gives `out_valid`=1 with that data after edge N, when M is empty or drains at N.
- Throughput: 1 bundle/cycle while `out_ready`=1, in both modes.
- SKID=1, `out_ready` low with M full:
  - one more bundle is accepted into S.
  - `in_ready` falls the cycle after.
  - it rises the cycle after the first subsequent `out_fire`.
- Simultaneous `in_fire`, `out_fire` and full S: impossible, because `in_ready`=0.
- Simultaneous `in_fire` and `out_fire` with S empty: M is replaced. Occupancy is unchanged and no bubble appears.
- Reset mid-transfer: held bundles are dropped. Outputs read zero after the reset edge.

## Test plan
- Reset check: assert `rst` with M and S full (`in_data` all 0xA5) → next cycle `out_valid`=0, `out_we`=0, `out_data`=0, `occupancy`=0; `in_ready`=1 once `rst` is released.
- Streaming, SKID=1, `out_ready`=1: bundles B0..B7 (lane0 = i, lane1 = 0x100+i, `in_we`=2'b11) on consecutive cycles → outputs B0..B7 on consecutive cycles, 1-cycle latency, no gaps.
- Backpressure: drop `out_ready` while B0 is in M and offer B1, B2 → B1 lands in S, `occupancy`=2, `in_ready`=0 next cycle, B2 is held. Release `out_ready` → outputs B0, B1, B2 in order.
- Flush with both entries full plus a new `in_valid` in the same cycle → `occupancy`=0, `out_we`=0, `out_data`=0 next cycle; the new bundle does not appear.
- Bubble: single bundle with `in_we`=2'b01 retired with no follow-up → the next cycle shows `out_valid`=0, `out_we`=2'b00, `out_data`=0.
- SKID=0, LANES=1, WIDTH=32:
  - `in_ready` follows `out_ready` within the same cycle while M is full.
  - alternating `out_ready` 1/0 over 0x10..0x17 → each word seen exactly once, in order.
